// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional performance counters in stall_ctrl are built only when STALL_PERF_EN is defined.
package stall_ctrl_pkg;

    typedef logic [5:0] StallBus;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int StallPc = 0;
    localparam int StallIf = 1;
    localparam int StallEx = 3;

    // Each request holds its own stage and everything upstream of it
    localparam StallBus StallReqMem  = 6'b011111;
    localparam StallBus StallReqEx   = 6'b001111;
    localparam StallBus StallReqId   = 6'b000111;
    localparam StallBus StallReqIf   = 6'b000011;
    localparam StallBus StallReqNone = 6'b000000;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        WAIT_IF  = 2'b01,
        REDIRECT = 2'b10
    } CtrlState;

    function automatic logic [31:0] satInc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/stall_ctrl_prio.sv
// Combinational priority encoder turning the four stage stall requests into the stall bus.
// The deepest requesting stage wins because it freezes the most of the pipeline.
module stall_prio
    import stall_ctrl_pkg::*;
#(
    parameter int STALL_W = 6
) (
    input  logic               stallreq_if_i,
    input  logic               stallreq_id_i,
    input  logic               stallreq_ex_i,
    input  logic               stallreq_mem_i,
    output logic [STALL_W-1:0] stall_o
);

    always_comb begin
        stall_o = '0;
        if (stallreq_mem_i) begin
            stall_o[5:0] = StallReqMem;
        end else if (stallreq_ex_i) begin
            stall_o[5:0] = StallReqEx;
        end else if (stallreq_id_i) begin
            stall_o[5:0] = StallReqId;
        end else if (stallreq_if_i) begin
            stall_o[5:0] = StallReqIf;
        end else begin
            stall_o[5:0] = StallReqNone;
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: stall bus generation plus taken-branch recovery FSM.
// Define STALL_PERF_EN to build the saturating stall-cycle and flush performance counters.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic [STALL_W-1:0] stall,
    output logic               flush_o,
    output logic               pc_redirect_o,
    output logic [ADDR_W-1:0]  pc_target_o,
    output logic [31:0]        stall_cycles_o,
    output logic [31:0]        flush_count_o
);

    CtrlState           state_q;
    logic               flush_q;
    logic               redirect_q;
    logic [ADDR_W-1:0]  target_q;
    logic [STALL_W-1:0] prioStall;
    logic               branchAccept;
    logic               redirectDone;

    stall_prio #(
        .STALL_W(STALL_W)
    ) u_prio (
        .stallreq_if_i (stallreq_if),
        .stallreq_id_i (stallreq_id),
        .stallreq_ex_i (stallreq_ex),
        .stallreq_mem_i(stallreq_mem),
        .stall_o       (prioStall)
    );

    // While a branch waits for the in-flight fetch, PC and IF must not advance down the wrong path
    always_comb begin
        stall = prioStall;
        if (state_q == WAIT_IF) begin
            stall[StallPc] = Stop;
            stall[StallIf] = Stop;
        end
    end

    assign branchAccept = branch_flag_i && (stall[StallEx] == NoStop) && (state_q == RUN);
    assign redirectDone = (state_q == REDIRECT) && (stall[StallPc] == NoStop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (branchAccept) begin
                        target_q <= branch_target_i;
                        flush_q  <= 1'b1;
                        if (stallreq_if) begin
                            state_q    <= WAIT_IF;
                            redirect_q <= 1'b0;
                        end else begin
                            state_q    <= REDIRECT;
                            redirect_q <= 1'b1;
                        end
                    end
                end
                WAIT_IF: begin
                    if (!stallreq_if) begin
                        state_q    <= REDIRECT;
                        redirect_q <= 1'b1;
                    end
                end
                REDIRECT: begin
                    // A held PC would drop the redirect, so leave only once pc_reg can load it
                    if (redirectDone) begin
                        state_q    <= RUN;
                        flush_q    <= 1'b0;
                        redirect_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    flush_q    <= 1'b0;
                    redirect_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush_o       = flush_q;
    assign pc_redirect_o = redirect_q;
    assign pc_target_o   = target_q;

`ifdef STALL_PERF_EN
    logic [31:0] stallCycles_q;
    logic [31:0] stallCycles_d;
    logic [31:0] flushCount_q;
    logic [31:0] flushCount_d;

    always_comb begin
        stallCycles_d = stallCycles_q;
        flushCount_d  = flushCount_q;
        if (stall[StallPc] == Stop) begin
            stallCycles_d = satInc(stallCycles_q);
        end
        if (redirectDone) begin
            flushCount_d = satInc(flushCount_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCycles_q <= '0;
            flushCount_q  <= '0;
        end else begin
            stallCycles_q <= stallCycles_d;
            flushCount_q  <= flushCount_d;
        end
    end

    assign stall_cycles_o = stallCycles_q;
    assign flush_count_o  = flushCount_q;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_count_o  = 32'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl: priority bus, branch recovery paths and reset.
// Counter checks follow STALL_PERF_EN so the bench matches whichever build it is compiled with.
module tb_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [5:0]  stall;
    logic        flush_o;
    logic        pc_redirect_o;
    logic [31:0] pc_target_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_count_o;

    int passCount;
    int checkCount;

    stall_ctrl #(
        .STALL_W(6),
        .ADDR_W (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .stall          (stall),
        .flush_o        (flush_o),
        .pc_redirect_o  (pc_redirect_o),
        .pc_target_o    (pc_target_o),
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge
    task automatic test_reset;
        rst = 1'b1;
        stallreq_if = 1'b0;
        stallreq_id = 1'b0;
        stallreq_ex = 1'b0;
        stallreq_mem = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'd0;
        #1;
        checkCount++; if (stall !== 6'b000000) $display("FAIL reset_stall: got %b want 000000", stall); else passCount++;
        checkCount++; if (flush_o !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush_o); else passCount++;
        checkCount++; if (pc_redirect_o !== 1'b0) $display("FAIL reset_redirect: got %b want 0", pc_redirect_o); else passCount++;
        checkCount++; if (pc_target_o !== 32'd0) $display("FAIL reset_target: got %h want 0", pc_target_o); else passCount++;
        checkCount++; if (stall_cycles_o !== 32'd0) $display("FAIL reset_stallcnt: got %0d want 0", stall_cycles_o); else passCount++;
        checkCount++; if (flush_count_o !== 32'd0) $display("FAIL reset_flushcnt: got %0d want 0", flush_count_o); else passCount++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_prio;
        stallreq_id = 1'b1;
        stallreq_mem = 1'b1;
        #1;
        checkCount++; if (stall !== 6'b011111) $display("FAIL prio_mem_id: got %b want 011111", stall); else passCount++;
        stallreq_mem = 1'b0;
        #1;
        checkCount++; if (stall !== 6'b000111) $display("FAIL prio_id: got %b want 000111", stall); else passCount++;
        stallreq_ex = 1'b1;
        stallreq_if = 1'b1;
        #1;
        checkCount++; if (stall !== 6'b001111) $display("FAIL prio_ex: got %b want 001111", stall); else passCount++;
        stallreq_ex = 1'b0;
        stallreq_id = 1'b0;
        #1;
        checkCount++; if (stall !== 6'b000011) $display("FAIL prio_if: got %b want 000011", stall); else passCount++;
        stallreq_if = 1'b0;
        #1;
        checkCount++; if (stall !== 6'b000000) $display("FAIL prio_none: got %b want 000000", stall); else passCount++;
        @(negedge clk);
    endtask

    task automatic test_idle_branch;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_1000;
        @(negedge clk);
        branch_flag_i = 1'b0;
        checkCount++; if (pc_redirect_o !== 1'b1) $display("FAIL idle_redirect: got %b want 1", pc_redirect_o); else passCount++;
        checkCount++; if (flush_o !== 1'b1) $display("FAIL idle_flush: got %b want 1", flush_o); else passCount++;
        checkCount++; if (pc_target_o !== 32'h0000_1000) $display("FAIL idle_target: got %h want 00001000", pc_target_o); else passCount++;
        @(negedge clk);
        checkCount++; if (pc_redirect_o !== 1'b0) $display("FAIL idle_back_redirect: got %b want 0", pc_redirect_o); else passCount++;
        checkCount++; if (flush_o !== 1'b0) $display("FAIL idle_back_flush: got %b want 0", flush_o); else passCount++;
    endtask

    task automatic test_busy_branch;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_2000;
        stallreq_if = 1'b1;
        @(negedge clk);
        // A second branch arriving while the first is pending must be ignored
        branch_target_i = 32'h0000_3000;
        checkCount++; if (flush_o !== 1'b1) $display("FAIL busy_flush1: got %b want 1", flush_o); else passCount++;
        checkCount++; if (pc_redirect_o !== 1'b0) $display("FAIL busy_redirect1: got %b want 0", pc_redirect_o); else passCount++;
        checkCount++; if (stall[1:0] !== 2'b11) $display("FAIL busy_stall1: got %b want 11", stall[1:0]); else passCount++;
        @(negedge clk);
        branch_flag_i = 1'b0;
        checkCount++; if (flush_o !== 1'b1) $display("FAIL busy_flush2: got %b want 1", flush_o); else passCount++;
        checkCount++; if (pc_redirect_o !== 1'b0) $display("FAIL busy_redirect2: got %b want 0", pc_redirect_o); else passCount++;
        stallreq_if = 1'b0;
        #1;
        checkCount++; if (stall !== 6'b000011) $display("FAIL busy_forced_stall: got %b want 000011", stall); else passCount++;
        @(negedge clk);
        checkCount++; if (pc_redirect_o !== 1'b1) $display("FAIL busy_redirect: got %b want 1", pc_redirect_o); else passCount++;
        checkCount++; if (flush_o !== 1'b1) $display("FAIL busy_flush3: got %b want 1", flush_o); else passCount++;
        checkCount++; if (pc_target_o !== 32'h0000_2000) $display("FAIL busy_target: got %h want 00002000", pc_target_o); else passCount++;
        @(negedge clk);
        checkCount++; if (pc_redirect_o !== 1'b0) $display("FAIL busy_redirect_once: got %b want 0", pc_redirect_o); else passCount++;
        checkCount++; if (flush_o !== 1'b0) $display("FAIL busy_flush_end: got %b want 0", flush_o); else passCount++;
    endtask

    task automatic test_mem_hold;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_4000;
        @(negedge clk);
        branch_flag_i = 1'b0;
        stallreq_mem = 1'b1;
        checkCount++; if (pc_redirect_o !== 1'b1) $display("FAIL hold_redirect1: got %b want 1", pc_redirect_o); else passCount++;
        @(negedge clk);
        checkCount++; if (pc_redirect_o !== 1'b1) $display("FAIL hold_redirect2: got %b want 1", pc_redirect_o); else passCount++;
        @(negedge clk);
        stallreq_mem = 1'b0;
        checkCount++; if (pc_redirect_o !== 1'b1) $display("FAIL hold_redirect3: got %b want 1", pc_redirect_o); else passCount++;
        checkCount++; if (pc_target_o !== 32'h0000_4000) $display("FAIL hold_target: got %h want 00004000", pc_target_o); else passCount++;
        @(negedge clk);
        checkCount++; if (pc_redirect_o !== 1'b0) $display("FAIL hold_release: got %b want 0", pc_redirect_o); else passCount++;
`ifdef STALL_PERF_EN
        checkCount++; if (flush_count_o !== 32'd3) $display("FAIL hold_flushcnt: got %0d want 3", flush_count_o); else passCount++;
`else
        checkCount++; if (flush_count_o !== 32'd0) $display("FAIL hold_flushcnt: got %0d want 0", flush_count_o); else passCount++;
`endif
    endtask

    task automatic test_mem_branch;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_5000;
        stallreq_mem = 1'b1;
        @(negedge clk);
        checkCount++; if (pc_redirect_o !== 1'b0) $display("FAIL membr_blocked_redirect: got %b want 0", pc_redirect_o); else passCount++;
        checkCount++; if (flush_o !== 1'b0) $display("FAIL membr_blocked_flush: got %b want 0", flush_o); else passCount++;
        checkCount++; if (pc_target_o !== 32'h0000_4000) $display("FAIL membr_blocked_target: got %h want 00004000", pc_target_o); else passCount++;
        stallreq_mem = 1'b0;
        @(negedge clk);
        branch_flag_i = 1'b0;
        checkCount++; if (pc_redirect_o !== 1'b1) $display("FAIL membr_redirect: got %b want 1", pc_redirect_o); else passCount++;
        checkCount++; if (pc_target_o !== 32'h0000_5000) $display("FAIL membr_target: got %h want 00005000", pc_target_o); else passCount++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_6000;
        stallreq_if = 1'b1;
        @(negedge clk);
        branch_flag_i = 1'b0;
        checkCount++; if (flush_o !== 1'b1) $display("FAIL rstmid_pending: got %b want 1", flush_o); else passCount++;
        #2;
        rst = 1'b1;
        #1;
        checkCount++; if (flush_o !== 1'b0) $display("FAIL rstmid_flush: got %b want 0", flush_o); else passCount++;
        checkCount++; if (pc_redirect_o !== 1'b0) $display("FAIL rstmid_redirect: got %b want 0", pc_redirect_o); else passCount++;
        checkCount++; if (pc_target_o !== 32'd0) $display("FAIL rstmid_target: got %h want 0", pc_target_o); else passCount++;
        checkCount++; if (stall !== 6'b000011) $display("FAIL rstmid_stall: got %b want 000011", stall); else passCount++;
        @(negedge clk);
        stallreq_if = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCount++; if (pc_redirect_o !== 1'b0) $display("FAIL rstmid_no_redirect%0d: got %b want 0", i, pc_redirect_o); else passCount++;
            checkCount++; if (flush_o !== 1'b0) $display("FAIL rstmid_no_flush%0d: got %b want 0", i, flush_o); else passCount++;
        end
    endtask

    task automatic test_perf;
        stallreq_if = 1'b1;
        repeat (3) @(negedge clk);
        stallreq_if = 1'b0;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_7000;
        @(negedge clk);
        branch_flag_i = 1'b0;
        @(negedge clk);
`ifdef STALL_PERF_EN
        checkCount++; if (stall_cycles_o !== 32'd3) $display("FAIL perf_stallcnt: got %0d want 3", stall_cycles_o); else passCount++;
        checkCount++; if (flush_count_o !== 32'd1) $display("FAIL perf_flushcnt: got %0d want 1", flush_count_o); else passCount++;
`else
        checkCount++; if (stall_cycles_o !== 32'd0) $display("FAIL perf_stallcnt: got %0d want 0", stall_cycles_o); else passCount++;
        checkCount++; if (flush_count_o !== 32'd0) $display("FAIL perf_flushcnt: got %0d want 0", flush_count_o); else passCount++;
`endif
        checkCount++; if (pc_target_o !== 32'h0000_7000) $display("FAIL perf_target: got %h want 00007000", pc_target_o); else passCount++;
    endtask

    initial begin
        passCount = 0;
        checkCount = 0;
        test_reset();
        test_prio();
        test_idle_branch();
        test_busy_branch();
        test_mem_hold();
        test_mem_branch();
        test_reset_mid();
        test_perf();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. Collects stall requests from IF, ID, EX and MEM and drives the 6-bit `stall` bus consumed by `pc_reg` and every pipeline register. It also owns taken-branch recovery. A branch resolved in EX is captured and held pending while IF finishes an in-flight memory fetch. It is then issued as a PC redirect together with a squash of the wrong-path IF/ID and ID/EX contents.

## Interface
Parameters:
- `STALL_W`, default 6: stall bus width; bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- `ADDR_W`, default 32: PC width.

Ports:
- `clk`: input, 1 bit. Single clock.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `stallreq_if`: input, 1 bit. IF fetch is in progress and its result is not ready.
- `stallreq_id`: input, 1 bit. ID load-use hazard.
- `stallreq_ex`: input, 1 bit. EX multi-cycle operation.
- `stallreq_mem`: input, 1 bit. MEM access is in progress.
- `branch_flag_i`: input, 1 bit. EX resolved a taken branch or jump (level).
- `branch_target_i`: input, `ADDR_W` bits. Target PC for `branch_flag_i`.
- `stall`: output, `STALL_W` bits. Per-stage hold; `Stop`=1.
- `flush_o`: output, 1 bit. Squash IF/ID and ID/EX to NOP on the next edge.
- `pc_redirect_o`: output, 1 bit. `pc_reg` loads `pc_target_o`.
- `pc_target_o`: output, `ADDR_W` bits. Registered redirect target.
- `stall_cycles_o`: output, 32 bits. Performance counter (see Configuration).
- `flush_count_o`: output, 32 bits. Performance counter (see Configuration).

## Operation
**Stall bus.** Combinational, highest-priority request wins:
- `stallreq_mem` → 6'b011111
- otherwise `stallreq_ex` → 6'b001111
- otherwise `stallreq_id` → 6'b000111
- otherwise `stallreq_if` → 6'b000011
- otherwise 6'b000000

While state is `WAIT_IF`, bits [1:0] are forced to 1 regardless of the other requests.

**Branch acceptance.** A branch is accepted only when `branch_flag_i`=1, `stall[3]`=0 and state is `RUN`. It is ignored in any other state; EX holds a bubble there by construction. The accepted target is latched into `pc_target_o`.

**FSM states:**
- `RUN`
  - Accepted branch with `stallreq_if`=1 → `WAIT_IF`.
  - Accepted branch with `stallreq_if`=0 → `REDIRECT`.
- `WAIT_IF`
  - `flush_o`=1.
  - Waits for the fetch to finish: `stallreq_if`=0 → `REDIRECT`.
- `REDIRECT`
  - `flush_o`=1, `pc_redirect_o`=1.
  - Stays in `REDIRECT` while `stall[0]`=1, so a MEM stall cannot lose the redirect.
  - `stall[0]`=0 → `RUN`.
- `flush_o` and `pc_redirect_o` are decoded from the registered state, so they are glitch-free.

**Simultaneous events:**
- `stallreq_mem` together with `branch_flag_i`: `stall[3]`=1, so the branch is not accepted. EX holds it and it is accepted on the first cycle `stall[3]`=0.
- Branch accepted in the same cycle `stallreq_if` falls: the sampled `stallreq_if` value decides, giving `WAIT_IF` (one extra cycle) when it was still 1.

**Reset.** Reset asserted at any time, including mid-redirect: state → `RUN`; `pc_target_o`, both counters, `flush_o` and `pc_redirect_o` → 0. `stall` follows its inputs combinationally, so it reads 0 when no request is active. The pending branch is dropped.

## Timing
- Stall bus: zero-cycle latency from the requests.
- Branch accepted at edge N with IF idle: `pc_redirect_o` and `flush_o` are high during cycle N+1. `pc_reg` fetches the target from edge N+2.
- With IF busy: redirect is one cycle after the first cycle `stallreq_if`=0 is sampled in `WAIT_IF`.
- `flush_o` stays high for the whole pending plus redirect window; squash takes precedence over stall in the consumers.

## Configuration
- `STALL_PERF_EN` defined:
  - `stall_cycles_o` increments every cycle with `stall[0]`=1.
  - `flush_count_o` increments on each `REDIRECT`→`RUN` transition.
  - Both saturate at 32'hFFFFFFFF.
- `STALL_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Add to `defines.v`:
  - `StallBus`, `Stop`/`NoStop`.
  - FSM state encodings: `RUN`=2'b00, `WAIT_IF`=2'b01, `REDIRECT`=2'b10.
- One sub-module, `stall_prio`: purely combinational priority encoder from the four requests to the stall bus.
- The FSM, target latch and counters live in `stall_ctrl`.

## Test plan
- **Stall priority:** `stallreq_id`=1 and `stallreq_mem`=1 → `stall`=6'b011111. Drop mem → 6'b000111. Drop all → 0.
- **Idle-IF branch:** `branch_flag_i`=1, target 32'h0000_1000, all requests 0 → next cycle `pc_redirect_o`=1, `flush_o`=1, `pc_target_o`=32'h1000. `RUN` is back one cycle later.
- **Busy-IF branch:** branch accepted with `stallreq_if`=1 held 3 cycles → `flush_o`=1 for 3 cycles, `stall[1:0]`=2'b11, then `pc_redirect_o`=1 for exactly 1 cycle.
- **Redirect held by MEM stall:** `stallreq_mem`=1 for 2 cycles during `REDIRECT` → `pc_redirect_o` stays high for 3 cycles. `flush_count_o` +1 (with `STALL_PERF_EN`).
- **Reset mid-operation:** `rst` pulsed asynchronously while in `WAIT_IF` → `flush_o`, `pc_redirect_o` and `pc_target_o` are 0 immediately. No redirect occurs after release.
